// File: rtl/serial_out_sched.sv
// ---------------------------------------------------------------------------
// serial_out_sched
//   Configuration scheduler between the packet decoder and a bank of CH_NUM
//   serial_out channels. Each accepted configuration word is staged, then
//   written into a per-channel shadow. A write to the last channel index
//   commits every shadow to the active pattern registers in one cycle and
//   fires aligned start/stop pulses. Per-channel busy status is tracked
//   from the start/stop pulses and the channels' done ticks.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   i_cfg_valid         configuration word present
//   o_cfg_ready         scheduler idle and able to accept a word
//   i_cfg_sel           target channel index
//   i_cfg_output        output pattern for target channel
//   i_cfg_freq          frequency pattern for target channel
//   i_cfg_start/stop    start/stop request applied at commit
//   i_cfg_mode          0 = one-shot, 1 = repeat
//   i_ch_done           per-channel done tick
//   o_output_pattern    active output patterns, channel k at [k*DATA_BIT +: DATA_BIT]
//   o_freq_pattern      active frequency patterns, same packing
//   o_mode              active mode per channel
//   o_start/o_stop      one-cycle start/stop pulses per channel
//   o_ch_busy           channel currently running
//   o_commit_tick       one-cycle pulse on commit
//   o_err_tick          one-cycle pulse for an out-of-range channel index
// ---------------------------------------------------------------------------
module serial_out_sched #(
  parameter int unsigned DATA_BIT = 32,
  parameter int unsigned CH_NUM   = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_cfg_valid,
  output logic                         o_cfg_ready,
  input  logic [3:0]                   i_cfg_sel,
  input  logic [DATA_BIT-1:0]          i_cfg_output,
  input  logic [DATA_BIT-1:0]          i_cfg_freq,
  input  logic                         i_cfg_start,
  input  logic                         i_cfg_stop,
  input  logic                         i_cfg_mode,
  input  logic [CH_NUM-1:0]            i_ch_done,
  output logic [CH_NUM*DATA_BIT-1:0]   o_output_pattern,
  output logic [CH_NUM*DATA_BIT-1:0]   o_freq_pattern,
  output logic [CH_NUM-1:0]            o_mode,
  output logic [CH_NUM-1:0]            o_start,
  output logic [CH_NUM-1:0]            o_stop,
  output logic [CH_NUM-1:0]            o_ch_busy,
  output logic                         o_commit_tick,
  output logic                         o_err_tick
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  // Channel count widened by one bit so CH_NUM = 16 compares cleanly
  // against the 4-bit index.
  localparam logic [4:0] LP_CH = 5'(CH_NUM);

  state_t r_state;
  state_t w_state_nxt;

  logic                w_capture;
  logic                w_load;
  logic                w_commit;
  logic                w_err;
  logic                w_sel_ok;
  logic                w_sel_last;

  // Input staging
  logic [3:0]          r_stg_sel;
  logic [DATA_BIT-1:0] r_stg_out;
  logic [DATA_BIT-1:0] r_stg_freq;
  logic                r_stg_start;
  logic                r_stg_stop;
  logic                r_stg_mode;

  // Shadow registers
  logic [CH_NUM-1:0][DATA_BIT-1:0] r_sh_out;
  logic [CH_NUM-1:0][DATA_BIT-1:0] r_sh_freq;
  logic [CH_NUM-1:0]               r_sh_mode;
  logic [CH_NUM-1:0]               r_sh_start;
  logic [CH_NUM-1:0]               r_sh_stop;

  // Active registers and pulses
  logic [CH_NUM-1:0][DATA_BIT-1:0] r_act_out;
  logic [CH_NUM-1:0][DATA_BIT-1:0] r_act_freq;
  logic [CH_NUM-1:0]               r_act_mode;
  logic [CH_NUM-1:0]               r_start;
  logic [CH_NUM-1:0]               r_stop;
  logic [CH_NUM-1:0]               r_busy;
  logic                            r_commit;
  logic                            r_err;

  assign w_sel_ok   = ({1'b0, r_stg_sel} < LP_CH);
  assign w_sel_last = ({1'b0, r_stg_sel} == (LP_CH - 5'd1));

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_load      = 1'b0;
    w_commit    = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_cfg_valid) begin
          w_capture   = 1'b1;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (!w_sel_ok) begin
          w_err       = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_load      = 1'b1;
          w_state_nxt = w_sel_last ? S_COMMIT : S_IDLE;
        end
      end
      S_COMMIT: begin
        w_commit    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign o_cfg_ready = (r_state == S_IDLE);

  // -------------------------------------------------------------------------
  // Input staging
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stg_sel   <= '0;
      r_stg_out   <= '0;
      r_stg_freq  <= '0;
      r_stg_start <= 1'b0;
      r_stg_stop  <= 1'b0;
      r_stg_mode  <= 1'b0;
    end else if (w_capture) begin
      r_stg_sel   <= i_cfg_sel;
      r_stg_out   <= i_cfg_output;
      r_stg_freq  <= i_cfg_freq;
      r_stg_start <= i_cfg_start;
      r_stg_stop  <= i_cfg_stop;
      r_stg_mode  <= i_cfg_mode;
    end
  end

  // -------------------------------------------------------------------------
  // Shadow registers: last write wins; flags are consumed by the commit
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_out   <= '0;
      r_sh_freq  <= '0;
      r_sh_mode  <= '0;
      r_sh_start <= '0;
      r_sh_stop  <= '0;
    end else if (w_load) begin
      for (int unsigned k = 0; k < CH_NUM; k++) begin
        if (r_stg_sel == 4'(k)) begin
          r_sh_out[k]   <= r_stg_out;
          r_sh_freq[k]  <= r_stg_freq;
          r_sh_mode[k]  <= r_stg_mode;
          r_sh_start[k] <= r_stg_start;
          r_sh_stop[k]  <= r_stg_stop;
        end
      end
    end else if (w_commit) begin
      r_sh_start <= '0;
      r_sh_stop  <= '0;
    end
  end

  // -------------------------------------------------------------------------
  // Active registers and aligned pulses
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_act_out  <= '0;
      r_act_freq <= '0;
      r_act_mode <= '0;
      r_start    <= '0;
      r_stop     <= '0;
      r_commit   <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_commit <= w_commit;
      r_err    <= w_err;
      if (w_commit) begin
        r_act_out  <= r_sh_out;
        r_act_freq <= r_sh_freq;
        r_act_mode <= r_sh_mode;
        // Stop has priority over start on the same channel.
        r_start    <= r_sh_start & ~r_sh_stop;
        r_stop     <= r_sh_stop;
      end else begin
        r_start    <= '0;
        r_stop     <= '0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Busy tracking: start beats stop/done; done only ends one-shot runs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      for (int unsigned k = 0; k < CH_NUM; k++) begin
        if (r_start[k]) begin
          r_busy[k] <= 1'b1;
        end else if (r_stop[k]) begin
          r_busy[k] <= 1'b0;
        end else if (i_ch_done[k] && !r_act_mode[k]) begin
          r_busy[k] <= 1'b0;
        end
      end
    end
  end

  assign o_output_pattern = r_act_out;
  assign o_freq_pattern   = r_act_freq;
  assign o_mode           = r_act_mode;
  assign o_start          = r_start;
  assign o_stop           = r_stop;
  assign o_ch_busy        = r_busy;
  assign o_commit_tick    = r_commit;
  assign o_err_tick       = r_err;

endmodule
